// File: rtl/pipeline_mem_responder.sv
// Serialises IF-stage and MEM-stage memory requests onto one shared memory
// port (data first). Each port has a registered done/resp flag. Both flags are
// high together for exactly one cycle, which is the pipeline-advance condition.
module pipeline_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_mem_read,
  input  logic                      inst_mem_write,
  input  logic [ADDR_WIDTH-1:0]     inst_mem_address,
  input  logic [DATA_WIDTH-1:0]     inst_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]   inst_mem_byte_enable,
  output logic [DATA_WIDTH-1:0]     inst_mem_rdata,
  output logic                      inst_mem_resp,
  input  logic                      data_mem_read,
  input  logic                      data_mem_write,
  input  logic [ADDR_WIDTH-1:0]     data_mem_address,
  input  logic [DATA_WIDTH-1:0]     data_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]   data_mem_byte_enable,
  output logic [DATA_WIDTH-1:0]     data_mem_rdata,
  output logic                      data_mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [ADDR_WIDTH-1:0]     pmem_address,
  output logic [DATA_WIDTH-1:0]     pmem_wdata,
  output logic [DATA_WIDTH/8-1:0]   pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0]     pmem_rdata,
  input  logic                      pmem_resp
);

  typedef enum logic [1:0] {IDLE, DATA_BUSY, INST_BUSY} state_t;

  state_t                    state, state_next;
  logic                      inst_done_next, data_done_next;
  logic [DATA_WIDTH-1:0]     inst_rdata_next, data_rdata_next;
  logic                      pmem_read_next, pmem_write_next;
  logic [ADDR_WIDTH-1:0]     pmem_address_next;
  logic [DATA_WIDTH-1:0]     pmem_wdata_next;
  logic [DATA_WIDTH/8-1:0]   pmem_byte_enable_next;

  logic data_pending, inst_pending, data_idle, inst_idle;

  // Port classification; resp outputs double as the done flags.
  always_comb begin
    data_pending = (data_mem_read | data_mem_write) & ~data_mem_resp;
    inst_pending = (inst_mem_read | inst_mem_write) & ~inst_mem_resp;
    data_idle    = ~data_mem_read & ~data_mem_write & ~data_mem_resp;
    inst_idle    = ~inst_mem_read & ~inst_mem_write & ~inst_mem_resp;
  end

  // Next-state, done flags, rdata capture and shared-port request latching.
  always_comb begin
    state_next            = state;
    inst_done_next        = inst_mem_resp;
    data_done_next        = data_mem_resp;
    inst_rdata_next       = inst_mem_rdata;
    data_rdata_next       = data_mem_rdata;
    pmem_read_next        = pmem_read;
    pmem_write_next       = pmem_write;
    pmem_address_next     = pmem_address;
    pmem_wdata_next       = pmem_wdata;
    pmem_byte_enable_next = pmem_byte_enable;
    unique case (state)
      IDLE: begin
        if (inst_mem_resp && data_mem_resp) begin
          inst_done_next = 1'b0;
          data_done_next = 1'b0;
        end else begin
          if (data_pending) begin
            pmem_address_next     = data_mem_address;
            pmem_wdata_next       = data_mem_wdata;
            pmem_byte_enable_next = data_mem_byte_enable;
            pmem_write_next       = data_mem_write;
            pmem_read_next        = data_mem_read & ~data_mem_write;
            state_next            = DATA_BUSY;
          end else if (inst_pending) begin
            pmem_address_next     = inst_mem_address;
            pmem_wdata_next       = inst_mem_wdata;
            pmem_byte_enable_next = inst_mem_byte_enable;
            pmem_write_next       = inst_mem_write;
            pmem_read_next        = inst_mem_read & ~inst_mem_write;
            state_next            = INST_BUSY;
          end
          if (data_idle) data_done_next = 1'b1;
          if (inst_idle) inst_done_next = 1'b1;
        end
      end
      DATA_BUSY: begin
        if (pmem_resp) begin
          if (pmem_read) data_rdata_next = pmem_rdata;
          data_done_next  = 1'b1;
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
          state_next      = IDLE;
        end
      end
      INST_BUSY: begin
        if (pmem_resp) begin
          if (pmem_read) inst_rdata_next = pmem_rdata;
          inst_done_next  = 1'b1;
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      inst_mem_resp    <= 1'b0;
      data_mem_resp    <= 1'b0;
      inst_mem_rdata   <= '0;
      data_mem_rdata   <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else begin
      state            <= state_next;
      inst_mem_resp    <= inst_done_next;
      data_mem_resp    <= data_done_next;
      inst_mem_rdata   <= inst_rdata_next;
      data_mem_rdata   <= data_rdata_next;
      pmem_read        <= pmem_read_next;
      pmem_write       <= pmem_write_next;
      pmem_address     <= pmem_address_next;
      pmem_wdata       <= pmem_wdata_next;
      pmem_byte_enable <= pmem_byte_enable_next;
    end
  end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Bench for pipeline_mem_responder: a memory model with programmable wait
// states and spurious idle responses, plus a transaction-level model of the
// expected access order, response timing and returned read data.
module tb_pipeline_mem_responder;

  logic        clk, rst;
  logic        inst_mem_read, inst_mem_write, data_mem_read, data_mem_write;
  logic [31:0] inst_mem_address, inst_mem_wdata, data_mem_address, data_mem_wdata;
  logic [3:0]  inst_mem_byte_enable, data_mem_byte_enable;
  logic [31:0] inst_mem_rdata, data_mem_rdata;
  logic        inst_mem_resp, data_mem_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  pipeline_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_mem_read(inst_mem_read), .inst_mem_write(inst_mem_write),
    .inst_mem_address(inst_mem_address), .inst_mem_wdata(inst_mem_wdata),
    .inst_mem_byte_enable(inst_mem_byte_enable),
    .inst_mem_rdata(inst_mem_rdata), .inst_mem_resp(inst_mem_resp),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_byte_enable(data_mem_byte_enable),
    .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } acc_t;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  acc_t         log_q[$];
  logic [31:0]  log_rd_q[$];
  int           wait_q[$];
  logic [31:0]  rd_q[$];
  acc_t         lat;
  bit           mem_active = 0;
  int           remaining = 0;
  logic [31:0]  exp_drd = '0;
  logic [31:0]  exp_ird = '0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory side: logs each new access, holds it for its wait count, then
  // pulses pmem_resp; when no strobe is up it sometimes pulses a stray resp.
  task automatic mem_step();
    acc_t a;
    pmem_resp = 1'b0;
    if (!rst) begin
      mem_active = 0;
      return;
    end
    if (pmem_read || pmem_write) begin
      a = '{rd: pmem_read, wr: pmem_write, addr: pmem_address,
            wd: pmem_wdata, be: pmem_byte_enable};
      if (!mem_active) begin
        mem_active = 1;
        lat = a;
        log_q.push_back(a);
        remaining = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end else begin
        check_eq("pmem_stable", a, lat);
      end
      if (remaining == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
        log_rd_q.push_back(pmem_rdata);
        mem_active = 0;
      end else begin
        remaining--;
      end
    end else begin
      mem_active = 0;
      if ($urandom_range(0, 3) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_step();
  endtask

  // One pipeline advance. Entry and exit: both resp high in the current cycle.
  task automatic advance(input logic [1:0] dop, input logic [1:0] iop,
                         input logic [31:0] daddr, input logic [31:0] iaddr,
                         input logic [31:0] dwd, input logic [31:0] iwd,
                         input logic [3:0] dbe, input logic [3:0] ibe,
                         input int dw, input int iw);
    int   cycles, d_rise, i_rise, d_exp, i_exp, n;
    bit   dact, iact;
    acc_t ed, ei;
    dact = (dop != 2'b00);
    iact = (iop != 2'b00);
    n = int'(dact) + int'(iact);
    log_q.delete();
    log_rd_q.delete();
    wait_q.delete();
    if (dact) wait_q.push_back(dw);
    if (iact) wait_q.push_back(iw);
    data_mem_read = dop[0]; data_mem_write = dop[1];
    data_mem_address = daddr; data_mem_wdata = dwd; data_mem_byte_enable = dbe;
    inst_mem_read = iop[0]; inst_mem_write = iop[1];
    inst_mem_address = iaddr; inst_mem_wdata = iwd; inst_mem_byte_enable = ibe;
    tick();
    check_eq("resp_window_one_cycle", {data_mem_resp, inst_mem_resp}, 2'b00);
    cycles = 0; d_rise = 0; i_rise = 0;
    while (!(data_mem_resp && inst_mem_resp) && cycles < 60) begin
      tick();
      cycles++;
      if (d_rise == 0) begin
        if (data_mem_resp) d_rise = cycles;
      end else check_eq("data_resp_held", data_mem_resp, 1'b1);
      if (i_rise == 0) begin
        if (inst_mem_resp) i_rise = cycles;
      end else check_eq("inst_resp_held", inst_mem_resp, 1'b1);
    end
    d_exp = dact ? 2 + dw : 1;
    i_exp = iact ? (dact ? 4 + dw + iw : 2 + iw) : 1;
    check_eq("data_resp_time", d_rise, d_exp);
    check_eq("inst_resp_time", i_rise, i_exp);
    check_eq("access_count", log_q.size(), n);
    ed = '{rd: dop == 2'b01, wr: dop[1], addr: daddr, wd: dwd, be: dbe};
    ei = '{rd: iop == 2'b01, wr: iop[1], addr: iaddr, wd: iwd, be: ibe};
    if (log_q.size() == n && log_rd_q.size() == n) begin
      if (dact) begin
        check_eq("data_access", log_q[0], ed);
        if (dop == 2'b01) exp_drd = log_rd_q[0];
      end
      if (iact) begin
        check_eq("inst_access", log_q[n-1], ei);
        if (iop == 2'b01) exp_ird = log_rd_q[n-1];
      end
    end
    check_eq("data_rdata", data_mem_rdata, exp_drd);
    check_eq("inst_rdata", inst_mem_rdata, exp_ird);
    check_eq("pmem_strobes_idle", {pmem_read, pmem_write}, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {inst_mem_rdata, inst_mem_resp, data_mem_rdata, data_mem_resp,
                   pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}, '0);
  endtask

  // Reset in the middle of a data access that memory never answers.
  task automatic reset_mid_busy();
    wait_q.delete();
    log_q.delete();
    log_rd_q.delete();
    wait_q.push_back(1000);
    data_mem_read = 1'b1; data_mem_write = 1'b0; data_mem_address = 32'h3000;
    inst_mem_read = 1'b0; inst_mem_write = 1'b0;
    tick();
    tick();
    check_eq("busy_before_reset", {pmem_read, pmem_address}, {1'b1, 32'h3000});
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all_zero("reset_mid_busy_outputs");
    end
    rst = 1'b1;
    data_mem_read = 1'b0;
    wait_q.delete();
    mem_active = 0;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h5555AAAA;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    exp_drd = '0;
    exp_ird = '0;
    check_eq("late_resp_ignored", {pmem_read, pmem_write, data_mem_rdata, inst_mem_rdata}, '0);
    check_eq("idle_after_reset", {data_mem_resp, inst_mem_resp}, 2'b11);
  endtask

  initial begin
    rst = 1'b0;
    inst_mem_read = 0; inst_mem_write = 0; inst_mem_address = '0;
    inst_mem_wdata = '0; inst_mem_byte_enable = '0;
    data_mem_read = 0; data_mem_write = 0; data_mem_address = '0;
    data_mem_wdata = '0; data_mem_byte_enable = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst = 1'b1;
    tick();
    check_eq("first_idle_advance", {data_mem_resp, inst_mem_resp}, 2'b11);

    // Dual read, zero wait: data first, both resp at cycle 4.
    rd_q.push_back(32'hAAAA0001);
    rd_q.push_back(32'hBBBB0002);
    advance(2'b01, 2'b01, 32'h1000, 32'h60, 32'h0, 32'h0, 4'hF, 4'hF, 0, 0);
    check_eq("dual_read_data", data_mem_rdata, 32'hAAAA0001);
    check_eq("dual_read_inst", inst_mem_rdata, 32'hBBBB0002);
    // Data write with three wait states, inst idle.
    advance(2'b10, 2'b00, 32'h2004, 32'h0, 32'hDEADBEEF, 32'h0, 4'b0011, 4'h0, 3, 0);
    check_eq("write_keeps_rdata", data_mem_rdata, 32'hAAAA0001);
    // Inst-only read, data idle.
    advance(2'b00, 2'b01, 32'h0, 32'h80, 32'h0, 32'h0, 4'h0, 4'hF, 0, 1);
    // Read and write together on the data port.
    advance(2'b11, 2'b00, 32'h40, 32'h0, 32'h12345678, 32'h0, 4'hC, 4'h0, 1, 0);
    // Both idle: stray responses must not disturb anything.
    advance(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0);

    reset_mid_busy();

    for (int t = 0; t < 150; t++) begin
      advance(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, $urandom,
              4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    data_mem_read = 0; data_mem_write = 0; inst_mem_read = 0; inst_mem_write = 0;
    tick();
    check_eq("final_resp_clear", {data_mem_resp, inst_mem_resp}, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
